cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Clock-enable and debug-run controller for the single-cycle RISC-V core. It replaces the fixed divided CPU clock with a single-clock design: the core runs on `clk` and advances only on a one-cycle `cpu_en` pulse. It adds halt, debounced single-step, selectable run rate and PC breakpoints with resume. It sits between the board buttons/switches and the core's PC, register-file and data-memory write enables.

## Interface
- `ADDR_W`, 32: PC / breakpoint address width.
- `NUM_BP`, 2: number of PC breakpoint comparators (1..8).
- `MIN_SHIFT`, 20: run period is 2^(MIN_SHIFT+rate_sel) cycles.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronized step button must be stable before it is accepted.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  2  00 halt, 01 step, 10 run, 11 run-to-breakpoint.
- `rate_sel`  in  4  run-rate select.
- `step_btn`  in  1  raw asynchronous button.
- `pc`  in  ADDR_W  current PC of the core.
- `bp_addr`  in  NUM_BP*ADDR_W  breakpoint addresses; entry i is at [i*ADDR_W +: ADDR_W].
- `bp_en`  in  NUM_BP  per-breakpoint enable.
- `cpu_en`  out  1  one-cycle advance pulse, registered.
- `halted`  out  1  high in HALT, STEP_WAIT and BRK.
- `bp_hit`  out  NUM_BP  sticky mask of the breakpoint(s) that caused the last stop.
- `retire_cnt`  out  32  count of `cpu_en` pulses; wraps.

## Operation
- Step input path:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a new synchronized value.
  - A debounced rising edge produces a one-cycle `step_req`.
- Tick counter:
  - Counts 0 to period-1, then asserts `tick` for one cycle and wraps to 0.
  - A change of `rate_sel` clears the counter to 0.
- FSM states: HALT, STEP_WAIT, RUN, BRK.
- Next state is chosen from `mode` every cycle, except in BRK:
  - 00 → HALT.
  - 01 → STEP_WAIT.
  - 10/11 → RUN.
  - BRK is left only when `mode` changes away from 11 or on `step_req`.
- HALT: no pulses. `step_req` is ignored.
- STEP_WAIT: each `step_req` issues exactly one `cpu_en` pulse. Ticks are ignored.
- RUN with mode 10: each `tick` issues one pulse.
- RUN with mode 11: on `tick`, compare `pc` against every enabled breakpoint.
  - Any match: no pulse, go to BRK, `bp_hit` <= match mask.
  - No match: pulse.
- BRK:
  - No pulses.
  - `step_req` issues one pulse, which executes the breakpointed instruction without re-checking, then returns to RUN.
  - `bp_hit` holds until the next stop or reset.
- `retire_cnt` increments by 1 on every `cpu_en`. It wraps from FFFF_FFFF to 0.
- Simultaneous events:
  - A mode change in the same cycle as `tick` or `step_req`: the new mode governs and no pulse is issued that cycle.
  - `step_req` in RUN is ignored.
- Reset mid-operation:
  - All state clears within the reset cycle.
  - Any in-flight pulse is dropped and the debounced level becomes 0.
  - A button held through reset is accepted only after it is released and pressed again.

## Timing
- Reset values:
  - `cpu_en`=0, `halted`=1, `bp_hit`=0, `retire_cnt`=0.
  - FSM in HALT.
  - Tick counter and debounce counter at 0.
- `cpu_en` is asserted the cycle after the `tick` or `step_req` that causes it. It is never high two cycles in a row.
- Button latency: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 edge cycle + 1 pulse cycle.
- Breakpoint compare uses the `pc` sampled in the tick cycle. `bp_hit` and `halted` update the following cycle.
- `retire_cnt` updates in the same cycle `cpu_en` is high, i.e. it is visible one cycle after the pulse.
- `mode` and `rate_sel` are treated as synchronous. The board-level wrapper synchronizes the switches.

## Structure
- Package `cpu_dbg_pkg`:
  - State enum.
  - Mode constants MODE_HALT, MODE_STEP, MODE_RUN, MODE_BRK.
  - Default parameter constants.
- Sub-module `btn_debounce`: synchronizer, stability counter and rising-edge pulse, parametrised by DEBOUNCE_CYCLES.
- Breakpoint comparators are a generate loop producing the NUM_BP match vector.
- Tick counter and FSM live in `cpu_run_ctrl`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and MIN_SHIFT=2.
- Reset, mode=10, rate_sel=0 → `cpu_en` pulses every 4 cycles; `retire_cnt`=5 after 20 cycles; `halted`=0.
- mode=01, press `step_btn` for 10 cycles with a 1-cycle glitch before it → exactly one pulse, 8 cycles after the stable press begins (2 sync + 4 debounce + edge + pulse); the glitch produces none.
- mode=11, bp_addr[0]=0x10, bp_en=01, pc advancing 0x0,0x4,… per pulse:
  - PC reaches 0x10 → no pulse; `halted`=1; `bp_hit`=01; `retire_cnt`=4.
  - Then step press → one pulse, back to RUN, `bp_hit` still 01.
- mode=10, switch to 00 in a tick cycle → no pulse that cycle or after; `halted`=1 next cycle.
- rate_sel 0→1 mid-count → counter restarts; next pulse 8 cycles after the change.
- Force `retire_cnt` to FFFF_FFFF via 2^32 pulses (or a backdoor preload) → next pulse gives 0. Reset asserted during RUN → `cpu_en`=0 and `retire_cnt`=0 the following cycle.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU run/debug controller.
// Holds the run-state enum, the mode switch encodings and the default sizing.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_STEP_WAIT = 2'd1,
        ST_RUN       = 2'd2,
        ST_BRK       = 2'd3
    } run_state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_BRK  = 2'b11;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_NUM_BP          = 2;
    localparam int DEF_MIN_SHIFT       = 20;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

    // Both running modes share ST_RUN; mode 11 only adds the breakpoint check.
    function automatic run_state_t mode_state(input logic [1:0] m);
        case (m)
            MODE_HALT: return ST_HALT;
            MODE_STEP: return ST_STEP_WAIT;
            default:   return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces a raw push button and emits a one-cycle pulse
// on each accepted press.
module btn_debounce
    import cpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_a;
    logic             sync_b;
    logic [1:0]       primed;
    logic             stable;
    logic             stable_q;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // A press is only honoured once the button has been seen released after
    // reset, so a button held through reset cannot fire on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            primed   <= 2'b00;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            rise     <= 1'b0;
        end else begin
            sync_a   <= btn;
            sync_b   <= sync_a;
            primed   <= {primed[0], 1'b1};
            stable_q <= stable;

            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (primed[1] && !sync_b && !stable) begin
                armed <= 1'b1;
            end

            rise <= stable & ~stable_q & armed;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Clock-enable and debug-run controller: halt, single-step, rate-divided run
// and run-to-breakpoint, all producing a one-cycle cpu_en advance pulse.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int NUM_BP          = DEF_NUM_BP,
    parameter int MIN_SHIFT       = DEF_MIN_SHIFT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic [3:0]               rate_sel,
    input  logic                     step_btn,
    input  logic [ADDR_W-1:0]        pc,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    output logic                     cpu_en,
    output logic                     halted,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic [31:0]              retire_cnt
);

    localparam int CNT_W = MIN_SHIFT + 16;

    run_state_t        state;
    run_state_t        next_state;
    logic [1:0]        mode_q;
    logic [3:0]        rate_q;
    logic [CNT_W-1:0]  tick_cnt;
    logic [CNT_W-1:0]  period_m1;
    logic              rate_changed;
    logic              mode_changed;
    logic              tick;
    logic              step_req;
    logic              pulse;
    logic              hit_load;
    logic [NUM_BP-1:0] bp_match;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk  (clk),
        .reset(reset),
        .btn  (step_btn),
        .rise (step_req)
    );

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        assign bp_match[i] = bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W]);
    end

    assign period_m1    = (CNT_W'(1) << (MIN_SHIFT + int'(rate_sel))) - CNT_W'(1);
    assign rate_changed = (rate_sel != rate_q);
    assign mode_changed = (mode != mode_q);
    assign tick         = (tick_cnt == period_m1) && !rate_changed;
    assign halted       = (state != ST_RUN);

    // A mode change wins over any tick or step request in the same cycle:
    // the state follows the new mode and nothing is issued.
    always_comb begin
        next_state = state;
        pulse      = 1'b0;
        hit_load   = 1'b0;
        if (state == ST_BRK) begin
            if (mode != MODE_BRK) begin
                next_state = mode_state(mode);
            end else if (step_req) begin
                pulse      = 1'b1;
                next_state = ST_RUN;
            end
        end else begin
            next_state = mode_state(mode);
            if (!mode_changed) begin
                case (state)
                    ST_STEP_WAIT: pulse = step_req;
                    ST_RUN: begin
                        if (tick) begin
                            if (mode == MODE_BRK && |bp_match) begin
                                next_state = ST_BRK;
                                hit_load   = 1'b1;
                            end else begin
                                pulse = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Gating on cpu_en keeps the advance pulse from ever lasting two cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_HALT;
            mode_q     <= MODE_HALT;
            rate_q     <= '0;
            tick_cnt   <= '0;
            cpu_en     <= 1'b0;
            bp_hit     <= '0;
            retire_cnt <= '0;
        end else begin
            state      <= next_state;
            mode_q     <= mode;
            rate_q     <= rate_sel;
            tick_cnt   <= (rate_changed || tick) ? '0 : tick_cnt + CNT_W'(1);
            cpu_en     <= pulse & ~cpu_en;
            retire_cnt <= retire_cnt + 32'(cpu_en);
            if (hit_load) begin
                bp_hit <= bp_match;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4 and
// MIN_SHIFT=2, so a rate_sel of 0 gives a 4-cycle run period.
module tb_cpu_run_ctrl;
    import cpu_dbg_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [3:0]  rate_sel;
    logic        step_btn;
    logic [31:0] pc;
    logic [63:0] bp_addr;
    logic [1:0]  bp_en;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  bp_hit;
    logic [31:0] retire_cnt;

    int vectors = 0;
    int miscompares = 0;

    cpu_run_ctrl #(
        .ADDR_W         (32),
        .NUM_BP         (2),
        .MIN_SHIFT      (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .rate_sel  (rate_sel),
        .step_btn  (step_btn),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core: PC advances by one instruction per advance pulse.
    always @(negedge clk) begin
        if (reset) pc = 32'h0;
        else if (cpu_en) pc = pc + 32'h4;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] r);
        mode     = m;
        rate_sel = r;
        reset    = 1'b1;
        waitCycles(2);
        reset    = 1'b0;
    endtask

    task automatic watchPulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            waitCycles(1);
            if (cpu_en) pulses++;
        end
    endtask

    // Holds the button for 'hold' cycles and reports on which sampled cycle
    // the first pulse appeared and the retire count one cycle later.
    task automatic pressStep(input int hold, input int window,
                             output int first, output int pulses, output logic [31:0] ret_after);
        first     = 0;
        pulses    = 0;
        ret_after = 32'hDEAD_BEEF;
        step_btn  = 1'b1;
        for (int i = 1; i <= window; i++) begin
            waitCycles(1);
            if (i == hold) step_btn = 1'b0;
            if (first != 0 && i == first + 1) ret_after = retire_cnt;
            if (cpu_en) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        step_btn = 1'b0;
    endtask

    task automatic waitPulse(input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            waitCycles(1);
            if (cpu_en) seen = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] mask;
        int          pulses;
        int          first;
        logic [31:0] ret_after;
        logic        seen;

        reset    = 1'b1;
        mode     = MODE_RUN;
        rate_sel = 4'd0;
        step_btn = 1'b0;
        bp_addr  = 64'h0;
        bp_en    = 2'b00;

        // Reset values, then free run at a 4-cycle period.
        waitCycles(2);
        checkOutput("rst_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd1);
        checkOutput("rst_bp_hit", 32'(bp_hit), 32'd0);
        checkOutput("rst_retire", retire_cnt, 32'd0);
        reset = 1'b0;
        mask = 32'h0;
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            if (cpu_en) mask[i] = 1'b1;
        end
        checkOutput("run_pulse_pattern", mask, 32'h0008_8888);
        waitCycles(1);
        checkOutput("run_retire_5", retire_cnt, 32'd5);
        checkOutput("run_halted", 32'(halted), 32'd0);

        // Switch to halt exactly in a tick cycle.
        waitCycles(2);
        mode = MODE_HALT;
        waitCycles(1);
        checkOutput("halt_sw_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("halt_sw_halted", 32'(halted), 32'd1);
        watchPulses(8, pulses);
        checkOutput("halt_no_pulses", 32'(pulses), 32'd0);
        checkOutput("halt_retire", retire_cnt, 32'd5);

        // Rate change mid-count restarts the divider.
        applyStimulus(MODE_RUN, 4'd0);
        waitCycles(5);
        rate_sel = 4'd1;
        mask = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            waitCycles(1);
            if (cpu_en) mask[i] = 1'b1;
        end
        checkOutput("rate_restart", mask, 32'h0000_0200);

        // Single step with a one-cycle glitch ahead of the real press.
        applyStimulus(MODE_STEP, 4'd0);
        waitCycles(4);
        step_btn = 1'b1;
        waitCycles(1);
        step_btn = 1'b0;
        watchPulses(2, pulses);
        checkOutput("glitch_no_pulse", 32'(pulses), 32'd0);
        pressStep(10, 14, first, pulses, ret_after);
        checkOutput("step_latency", 32'(first), 32'd8);
        checkOutput("step_one_pulse", 32'(pulses), 32'd1);
        checkOutput("step_retire", retire_cnt, 32'd1);

        // Button held through reset must be released before it counts.
        step_btn = 1'b1;
        applyStimulus(MODE_STEP, 4'd0);
        watchPulses(14, pulses);
        checkOutput("held_no_pulse", 32'(pulses), 32'd0);
        step_btn = 1'b0;
        waitCycles(10);
        pressStep(10, 14, first, pulses, ret_after);
        checkOutput("held_repress_latency", 32'(first), 32'd8);

        // Run to breakpoint at 0x10; the disabled entry at 0x8 must not stop.
        bp_addr = {32'h0000_0008, 32'h0000_0010};
        bp_en   = 2'b01;
        applyStimulus(MODE_BRK, 4'd0);
        waitCycles(20);
        checkOutput("bp_halted", 32'(halted), 32'd1);
        checkOutput("bp_hit_mask", 32'(bp_hit), 32'd1);
        checkOutput("bp_retire_4", retire_cnt, 32'd4);
        checkOutput("bp_pc", pc, 32'h10);
        watchPulses(8, pulses);
        checkOutput("bp_hold_no_pulse", 32'(pulses), 32'd0);
        pressStep(10, 14, first, pulses, ret_after);
        checkOutput("bp_step_latency", 32'(first), 32'd8);
        checkOutput("bp_step_retire", ret_after, 32'd5);
        checkOutput("bp_resume_halted", 32'(halted), 32'd0);
        checkOutput("bp_hit_sticky", 32'(bp_hit), 32'd1);

        // Retire counter wrap, then reset landing on a tick.
        mode = MODE_HALT;
        waitCycles(3);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        waitCycles(1);
        release dut.retire_cnt;
        waitCycles(1);
        checkOutput("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        mode = MODE_RUN;
        waitPulse(20, seen);
        checkOutput("wrap_pulse_seen", 32'(seen), 32'd1);
        waitCycles(1);
        checkOutput("wrap_to_zero", retire_cnt, 32'd0);
        waitCycles(6);
        checkOutput("prereset_retire", retire_cnt, 32'd1);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("midrun_rst_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("midrun_rst_retire", retire_cnt, 32'd0);
        checkOutput("midrun_rst_halted", 32'(halted), 32'd1);
        reset = 1'b0;
        waitCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
